debug_frame_scheduler: RTL and testbench

- Shares the single 9-bit debug frame display path between two frame sources: received frames (rx) and frames queued for transmit (tx).
- Each source has a one-entry pending buffer. A round-robin scheduler grants the display to one source.
- The granted frame is held on the output for HOLD_CYCLES so the board display/LEDs stay readable.
- Sits between the UART rx/tx datapath and the board debug outputs. Also latches the 4-bit data register and counts dropped frames per source.

---
 rtl/debug_frame_scheduler_pkg.sv | 26 ++
 rtl/debug_frame_scheduler_pending_slot.sv | 37 +++
 rtl/debug_frame_scheduler.sv | 135 +++++++++++++
 tb/tb_debug_frame_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_frame_scheduler_pkg.sv
// Shared types and constants for the debug frame scheduler: FSM states,
// source encoding and the saturating drop counter helpers.
package debug_frame_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  typedef enum logic {
    SRC_RX = 1'b0,
    SRC_TX = 1'b1
  } src_t;

  localparam int DROP_W = 4;
  localparam logic [DROP_W-1:0] DROP_MAX = 4'd15;

  // Counting stops at DROP_MAX so a long burst of drops never wraps to a small value.
  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] count);
    if (count == DROP_MAX) begin
      return count;
    end
    return count + 1'b1;
  endfunction

endpackage

// File: rtl/debug_frame_scheduler_pending_slot.sv
// One-entry pending buffer for a frame source with a saturating drop counter.
// A load arriving while the entry is being cleared refills it in the same edge.
module debug_pending_slot
  import debug_frame_scheduler_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic              pending,
  output logic [DATA_W-1:0] data,
  output logic [DROP_W-1:0] drops
);

  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      pending <= 1'b0;
      data    <= '0;
      drops   <= '0;
    end else if (load) begin
      if (!pending || clear) begin
        pending <= 1'b1;
        data    <= load_data;
      end else begin
        // Full and not being drained: keep the older frame, count the loss.
        drops <= drop_inc(drops);
      end
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_frame_scheduler.sv
// Round-robin scheduler sharing the debug frame display between rx and tx
// frames; each granted frame is held for HOLD_CYCLES before the next grant.
module debug_frame_scheduler
  import debug_frame_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int FRAME_W     = 9,
  parameter int REG_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               debug,
  input  logic               rx_valid,
  input  logic [FRAME_W-1:0] rx_frame,
  input  logic               tx_valid,
  input  logic [FRAME_W-1:0] tx_frame,
  input  logic               reg_valid,
  input  logic [REG_W-1:0]   reg_data,
  output logic [FRAME_W-1:0] debug_frame,
  output logic               debug_src,
  output logic               debug_frame_valid,
  output logic [REG_W-1:0]   debug_reg,
  output logic [DROP_W-1:0]  rx_drops,
  output logic [DROP_W-1:0]  tx_drops
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_next;
  src_t               prio, prio_next;
  logic               grant;
  src_t               grant_src;
  logic               grant_rx, grant_tx;

  logic               rx_pending, tx_pending;
  logic [FRAME_W-1:0] rx_data, tx_data;

  debug_pending_slot #(.DATA_W(FRAME_W)) rx_slot (
    .clk       (clk),
    .rst       (rst),
    .enable    (debug),
    .load      (rx_valid),
    .load_data (rx_frame),
    .clear     (grant_rx),
    .pending   (rx_pending),
    .data      (rx_data),
    .drops     (rx_drops)
  );

  debug_pending_slot #(.DATA_W(FRAME_W)) tx_slot (
    .clk       (clk),
    .rst       (rst),
    .enable    (debug),
    .load      (tx_valid),
    .load_data (tx_frame),
    .clear     (grant_tx),
    .pending   (tx_pending),
    .data      (tx_data),
    .drops     (tx_drops)
  );

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    prio_next     = prio;
    grant         = 1'b0;
    grant_src     = SRC_RX;
    case (state)
      IDLE: begin
        if (rx_pending && tx_pending) begin
          grant     = 1'b1;
          grant_src = prio;
          if (prio == SRC_RX) begin
            prio_next = SRC_TX;
          end else begin
            prio_next = SRC_RX;
          end
        end else if (rx_pending) begin
          grant     = 1'b1;
          grant_src = SRC_RX;
          prio_next = SRC_TX;
        end else if (tx_pending) begin
          grant     = 1'b1;
          grant_src = SRC_TX;
          prio_next = SRC_RX;
        end
        if (grant) begin
          state_next    = SHOW;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      SHOW: begin
        // The expiry edge only returns to IDLE; the next grant is one edge later.
        if (hold_cnt == '0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant_rx = grant && (grant_src == SRC_RX);
  assign grant_tx = grant && (grant_src == SRC_TX);

  always_ff @(posedge clk) begin
    if (!rst || !debug) begin
      state             <= IDLE;
      hold_cnt          <= '0;
      prio              <= SRC_RX;
      debug_frame       <= '0;
      debug_src         <= 1'b0;
      debug_frame_valid <= 1'b0;
      debug_reg         <= '0;
    end else begin
      state             <= state_next;
      hold_cnt          <= hold_cnt_next;
      prio              <= prio_next;
      debug_frame_valid <= grant;
      if (grant) begin
        debug_frame <= grant_tx ? tx_data : rx_data;
        debug_src   <= grant_tx;
      end
      if (reg_valid) begin
        debug_reg <= reg_data;
      end
    end
  end

endmodule

// File: tb/tb_debug_frame_scheduler.sv
// Scoreboard bench for debug_frame_scheduler: expected displayed frames are
// queued with their arrival cycle as stimulus is driven, then matched on output.
module tb_debug_frame_scheduler;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, debug, rx_valid, tx_valid, reg_valid;
  logic [8:0] rx_frame, tx_frame;
  logic [3:0] reg_data;

  logic [8:0] debug_frame;
  logic       debug_src, debug_frame_valid;
  logic [3:0] debug_reg, rx_drops, tx_drops;

  logic [8:0] h1_frame;
  logic       h1_src, h1_valid;
  logic [3:0] h1_reg, h1_rx_drops, h1_tx_drops;

  typedef struct {
    logic [8:0] frame;
    logic       src;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_frame_scheduler #(.HOLD_CYCLES(HOLD), .FRAME_W(9), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .debug(debug),
    .rx_valid(rx_valid), .rx_frame(rx_frame),
    .tx_valid(tx_valid), .tx_frame(tx_frame),
    .reg_valid(reg_valid), .reg_data(reg_data),
    .debug_frame(debug_frame), .debug_src(debug_src),
    .debug_frame_valid(debug_frame_valid), .debug_reg(debug_reg),
    .rx_drops(rx_drops), .tx_drops(tx_drops)
  );

  debug_frame_scheduler #(.HOLD_CYCLES(1), .FRAME_W(9), .REG_W(4)) dut_h1 (
    .clk(clk), .rst(rst), .debug(debug),
    .rx_valid(rx_valid), .rx_frame(rx_frame),
    .tx_valid(tx_valid), .tx_frame(tx_frame),
    .reg_valid(reg_valid), .reg_data(reg_data),
    .debug_frame(h1_frame), .debug_src(h1_src),
    .debug_frame_valid(h1_valid), .debug_reg(h1_reg),
    .rx_drops(h1_rx_drops), .tx_drops(h1_tx_drops)
  );

  // Output monitor: every displayed frame must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (debug_frame_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got frame=%h src=%0d at cyc %0d, required no frame",
                 debug_frame, debug_src, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (debug_frame !== mon_e.frame || debug_src !== mon_e.src || cyc != mon_e.at) begin
          bad++;
          $display("FAIL frame_out: got frame=%h src=%0d cyc=%0d, required frame=%h src=%0d cyc=%0d",
                   debug_frame, debug_src, cyc, mon_e.frame, mon_e.src, mon_e.at);
        end else begin
          $display("txn frame=%h src=%0d cyc=%0d ok", debug_frame, debug_src, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] f, input logic s, input int at);
    exp_t e;
    e.frame = f;
    e.src   = s;
    e.at    = at;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    repeat (2 * HOLD + 6) tick();
  endtask

  task automatic soft_reset();
    drain();
    debug = 1'b0;
    tick();
    debug = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; debug = 1'b1;
    rx_valid = 1'b1; tx_valid = 1'b1; reg_valid = 1'b1;
    rx_frame = 9'h1FF; tx_frame = 9'h155; reg_data = 4'hF;
    tick();
    rx_valid = 1'b0; tx_valid = 1'b0; reg_valid = 1'b0;
    tick();
    total++; if (debug_frame !== 9'h0) begin bad++; $display("FAIL rst_frame: got %h required 000", debug_frame); end
    total++; if (debug_src !== 1'b0) begin bad++; $display("FAIL rst_src: got %0d required 0", debug_src); end
    total++; if (debug_frame_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0d required 0", debug_frame_valid); end
    total++; if (debug_reg !== 4'h0) begin bad++; $display("FAIL rst_reg: got %h required 0", debug_reg); end
    total++; if (rx_drops !== 4'h0 || tx_drops !== 4'h0) begin bad++; $display("FAIL rst_drops: got rx=%0d tx=%0d required 0 0", rx_drops, tx_drops); end
    rst = 1'b1; debug = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_frame = 9'(i + 5);
      tick();
      rx_valid = 1'b0;
      tick();
    end
    total++; if (debug_frame !== 9'h0 || debug_frame_valid !== 1'b0) begin bad++; $display("FAIL dbg0_out: got frame=%h valid=%0d required 000 0", debug_frame, debug_frame_valid); end
    total++; if (rx_drops !== 4'h0) begin bad++; $display("FAIL dbg0_rx_drops: got %0d required 0", rx_drops); end
    debug = 1'b1;
    tick();
  endtask

  task automatic test_single_rx();
    int k;
    k = cyc;
    rx_frame = 9'h1A5; rx_valid = 1'b1;
    push(9'h1A5, 1'b0, k + 2);
    tick();
    rx_valid = 1'b0; rx_frame = 9'h000;
    tick();
    for (int i = 0; i < HOLD; i++) begin
      total++;
      if (debug_frame !== 9'h1A5 || debug_src !== 1'b0) begin
        bad++; $display("FAIL hold_stable[%0d]: got frame=%h src=%0d required 1a5 0", i, debug_frame, debug_src);
      end
      total++;
      if (debug_frame_valid !== (i == 0)) begin
        bad++; $display("FAIL valid_pulse[%0d]: got %0d required %0d", i, debug_frame_valid, (i == 0));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_pair_round_robin();
    int k;
    soft_reset();
    k = cyc;
    rx_frame = 9'h011; tx_frame = 9'h122; rx_valid = 1'b1; tx_valid = 1'b1;
    push(9'h011, 1'b0, k + 2);
    push(9'h122, 1'b1, k + 2 + HOLD + 1);
    tick();
    rx_valid = 1'b0; tx_valid = 1'b0;
    tick();
    tick();
    // rx refills while tx still waits: pointer now favours tx, then rx follows.
    rx_frame = 9'h033; rx_valid = 1'b1;
    push(9'h033, 1'b0, k + 2 + 2 * (HOLD + 1));
    tick();
    rx_valid = 1'b0;
    drain();
    total++; if (rx_drops !== 4'h0 || tx_drops !== 4'h0) begin bad++; $display("FAIL pair_drops: got rx=%0d tx=%0d required 0 0", rx_drops, tx_drops); end
  endtask

  task automatic test_drops();
    int k;
    soft_reset();
    k = cyc;
    rx_frame = 9'h0A0; rx_valid = 1'b1;
    push(9'h0A0, 1'b0, k + 2);
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    rx_frame = 9'h0B0; rx_valid = 1'b1;
    push(9'h0B0, 1'b0, k + 7);
    tick();
    rx_frame = 9'h0C0;
    tick();
    rx_frame = 9'h0D0;
    tick();
    rx_valid = 1'b0;
    total++; if (rx_drops !== 4'd2) begin bad++; $display("FAIL drops_two: got %0d required 2", rx_drops); end
    tick();
    rx_frame = 9'h0F0; rx_valid = 1'b1;
    for (int j = 0; j < 5; j++) push(9'h0F0, 1'b0, k + 12 + 5 * j);
    repeat (20) tick();
    rx_valid = 1'b0;
    total++; if (rx_drops !== 4'd15) begin bad++; $display("FAIL drops_sat: got %0d required 15", rx_drops); end
    total++; if (tx_drops !== 4'd0) begin bad++; $display("FAIL drops_tx_idle: got %0d required 0", tx_drops); end
    drain();
    total++; if (rx_drops !== 4'd15) begin bad++; $display("FAIL drops_hold: got %0d required 15", rx_drops); end
  endtask

  task automatic test_grant_reload();
    int k;
    soft_reset();
    k = cyc;
    rx_frame = 9'h0AA; rx_valid = 1'b1;
    push(9'h0AA, 1'b0, k + 2);
    tick();
    rx_frame = 9'h0BB;
    push(9'h0BB, 1'b0, k + 2 + HOLD + 1);
    tick();
    rx_valid = 1'b0;
    drain();
    total++; if (rx_drops !== 4'd0) begin bad++; $display("FAIL reload_drops: got %0d required 0", rx_drops); end
  endtask

  task automatic test_reg_debug_off();
    int k;
    soft_reset();
    k = cyc;
    rx_frame = 9'h0C3; rx_valid = 1'b1;
    push(9'h0C3, 1'b0, k + 2);
    tick();
    rx_valid = 1'b0;
    tick();
    rx_frame = 9'h0C4; rx_valid = 1'b1;
    tick();
    rx_frame = 9'h0C5; reg_valid = 1'b1; reg_data = 4'hB;
    tick();
    rx_valid = 1'b0; reg_valid = 1'b0; reg_data = 4'h0;
    total++; if (debug_reg !== 4'hB) begin bad++; $display("FAIL reg_latch: got %h required b", debug_reg); end
    total++; if (rx_drops !== 4'd1) begin bad++; $display("FAIL reg_pre_drops: got %0d required 1", rx_drops); end
    debug = 1'b0;
    tick();
    debug = 1'b1;
    total++; if (debug_reg !== 4'h0) begin bad++; $display("FAIL off_reg: got %h required 0", debug_reg); end
    total++; if (debug_frame !== 9'h0 || debug_src !== 1'b0 || debug_frame_valid !== 1'b0) begin
      bad++; $display("FAIL off_frame: got frame=%h src=%0d valid=%0d required 000 0 0", debug_frame, debug_src, debug_frame_valid);
    end
    total++; if (rx_drops !== 4'd0) begin bad++; $display("FAIL off_drops: got %0d required 0", rx_drops); end
    // An idle FSM grants a fresh frame with the minimum two-edge latency.
    tx_frame = 9'h0C6; tx_valid = 1'b1;
    push(9'h0C6, 1'b1, k + 7);
    tick();
    tx_valid = 1'b0;
    drain();
  endtask

  task automatic test_hold_one();
    int k;
    soft_reset();
    k = cyc;
    rx_frame = 9'h0E1; tx_frame = 9'h0E2; rx_valid = 1'b1; tx_valid = 1'b1;
    push(9'h0E1, 1'b0, k + 2);
    push(9'h0E2, 1'b1, k + 2 + HOLD + 1);
    tick();
    rx_valid = 1'b0; tx_valid = 1'b0;
    tick();
    total++; if (h1_valid !== 1'b1 || h1_frame !== 9'h0E1 || h1_src !== 1'b0) begin
      bad++; $display("FAIL h1_first: got valid=%0d frame=%h src=%0d required 1 0e1 0", h1_valid, h1_frame, h1_src);
    end
    tick();
    total++; if (h1_valid !== 1'b0 || h1_frame !== 9'h0E1) begin
      bad++; $display("FAIL h1_show: got valid=%0d frame=%h required 0 0e1", h1_valid, h1_frame);
    end
    tick();
    total++; if (h1_valid !== 1'b1 || h1_frame !== 9'h0E2 || h1_src !== 1'b1) begin
      bad++; $display("FAIL h1_second: got valid=%0d frame=%h src=%0d required 1 0e2 1", h1_valid, h1_frame, h1_src);
    end
    drain();
  endtask

  initial begin
    rst = 1'b0; debug = 1'b0;
    rx_valid = 1'b0; tx_valid = 1'b0; reg_valid = 1'b0;
    rx_frame = '0; tx_frame = '0; reg_data = '0;
    test_reset();
    test_single_rx();
    test_pair_round_robin();
    test_drops();
    test_grant_reload();
    test_reg_debug_off();
    test_hold_one();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_frames: got %0d frames still expected, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
